exec_sequencer: RTL

Multi-cycle control FSM for the single-issue ARM core. It fetches an instruction over a req/ack handshake and pulses the instruction-register load. It then samples the combinational instruction decoder's outputs and sequences the datapath: the extra Rs read cycle for register-specified shifts, the iterative multiplier with early termination, ALU execute, and the register/flag/PC writeback enables. It sits between the instruction memory, the decoder, the register file, and the ALU/multiplier units.

---
 rtl/exec_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the single-issue ARM core: fetch handshake, decode
// dispatch, Rs read, iterative multiply with early termination, execute and writeback.
module exec_sequencer #(
    parameter bit          MUL_EARLY_TERM = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             cond_pass,
    input  logic             dec_reg_w,
    input  logic             dec_alu_hot,
    input  logic             dec_mult_hot,
    input  logic             dec_is_immediate,
    input  logic             dec_immediate_shift,
    input  logic             dec_S_on,
    input  logic [31:0]      rs_operand,
    output logic             rf_rd_sel,
    output logic             rs_latch,
    output logic             alu_en,
    output logic             mult_clear,
    output logic             mult_step,
    output logic             mult_last,
    output logic             rf_we,
    output logic             flags_we,
    output logic             pc_we,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StRsRead,
        StMulRs,
        StMul,
        StExec,
        StWb
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             reg_w_q, reg_w_d;
    logic             s_on_q, s_on_d;
    logic             alu_hot_q, alu_hot_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       mul_last_idx;
    logic             unused_rs_low;

    // The low byte is always consumed by at least one multiplier step.
    assign unused_rs_low = ^rs_operand[7:0];

    // Iterations stop once the remaining upper bytes are pure sign extension.
    always_comb begin
        if (!MUL_EARLY_TERM) begin
            mul_last_idx = 2'd3;
        end else if ((&rs_operand[31:8]) || !(|rs_operand[31:8])) begin
            mul_last_idx = 2'd0;
        end else if ((&rs_operand[31:16]) || !(|rs_operand[31:16])) begin
            mul_last_idx = 2'd1;
        end else if ((&rs_operand[31:24]) || !(|rs_operand[31:24])) begin
            mul_last_idx = 2'd2;
        end else begin
            mul_last_idx = 2'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reg_w_d   = reg_w_q;
        s_on_d    = s_on_q;
        alu_hot_d = alu_hot_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_ack) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // A failed condition retires as a plain PC increment.
                reg_w_d   = dec_reg_w & cond_pass;
                s_on_d    = dec_S_on & cond_pass;
                alu_hot_d = dec_alu_hot;
                if (!cond_pass) begin
                    state_d = StWb;
                end else if (dec_mult_hot) begin
                    state_d = StMulRs;
                end else if (!dec_is_immediate && !dec_immediate_shift) begin
                    state_d = StRsRead;
                end else begin
                    state_d = StExec;
                end
            end
            StRsRead: state_d = StExec;
            StMulRs: begin
                cnt_d   = mul_last_idx;
                state_d = StMul;
            end
            StMul: begin
                if (cnt_q == 2'd0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StExec: state_d = StWb;
            StWb: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            reg_w_q   <= 1'b0;
            s_on_q    <= 1'b0;
            alu_hot_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reg_w_q   <= reg_w_d;
            s_on_q    <= s_on_d;
            alu_hot_q <= alu_hot_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        rf_rd_sel  = 1'b0;
        rs_latch   = 1'b0;
        alu_en     = 1'b0;
        mult_clear = 1'b0;
        mult_step  = 1'b0;
        mult_last  = 1'b0;
        rf_we      = 1'b0;
        flags_we   = 1'b0;
        pc_we      = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            StRsRead: begin
                rf_rd_sel = 1'b1;
                rs_latch  = 1'b1;
            end
            StMulRs: begin
                rf_rd_sel  = 1'b1;
                rs_latch   = 1'b1;
                mult_clear = 1'b1;
            end
            StMul: begin
                mult_step = 1'b1;
                mult_last = (cnt_q == 2'd0);
            end
            StExec: alu_en = alu_hot_q;
            StWb: begin
                rf_we    = reg_w_q;
                flags_we = s_on_q;
                pc_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle) && (state_q != StFetch);
    assign retired = retired_q;

endmodule
